bank_isu_arb: RTL and testbench

- Upstream feeder of the bank issue queue (IQ).
- Accepts requests from 4 independent channels, buffers one request per channel, and round-robin arbitrates among them.
- Allocates a free ROB id to each winner and presents a registered request bundle to the IQ over a valid/allowIn handshake.
- ROB ids are returned through a release port when the bank retires a request.

---
 rtl/bank_isu_arb_pkg.sv | 29 ++
 rtl/bank_rr_arb4.sv | 27 ++
 rtl/bank_isu_arb.sv | 124 ++++++++++++
 tb/tb_bank_isu_arb.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/bank_isu_arb_pkg.sv
// Shared bank definitions: field widths, the request payload, and the ROB id
// allocator helper used by the issue arbiter.
package bank_isu_arb_pkg;

   localparam int ROB_ID_W  = 3;
   localparam int CH_ID_W   = 2;
   localparam int OPCODE_W  = 2;
   localparam int SWO_W     = 7;
   localparam int WBUF_W    = 8;
   localparam int CLSTATE_W = 4;
   localparam int ROB_IDS   = 1 << ROB_ID_W;

   // 21-bit request payload carried from a channel to the IQ.
   typedef struct packed {
      logic [OPCODE_W-1:0]  opcode;
      logic [SWO_W-1:0]     swo;
      logic [WBUF_W-1:0]    wbuf;
      logic [CLSTATE_W-1:0] state;
   } bank_req_t;

   // Lowest-index clear bit; returns 0 when none is clear (caller gates on full).
   function automatic logic [ROB_ID_W-1:0] first_clear(input logic [ROB_IDS-1:0] busy);
      first_clear = '0;
      for (int i = ROB_IDS - 1; i >= 0; i--) begin
         if (!busy[i]) first_clear = ROB_ID_W'(i);
      end
   endfunction

endpackage

// File: rtl/bank_rr_arb4.sv
// 4-input round-robin picker: first requester at or after ptr_i, wrapping.
module bank_rr_arb4 (
   input  logic [3:0] req_i,
   input  logic [1:0] ptr_i,
   output logic [3:0] gnt_o,
   output logic [1:0] idx_o,
   output logic       any_o
);

   logic [1:0] cand;

   // Scan farthest offset first so the nearest requester overwrites last.
   always_comb begin
      idx_o = ptr_i;
      any_o = 1'b0;
      cand  = ptr_i;
      for (int k = 3; k >= 0; k--) begin
         cand = ptr_i + 2'(k);
         if (req_i[cand]) begin
            idx_o = cand;
            any_o = 1'b1;
         end
      end
      gnt_o = any_o ? (4'b0001 << idx_o) : 4'b0000;
   end

endmodule

// File: rtl/bank_isu_arb.sv
// Bank issue arbiter: per-channel hold registers, round-robin pick, ROB id
// free-list and a registered valid/allowIn output stage toward the IQ.
module bank_isu_arb
   import bank_isu_arb_pkg::*;
#(
   parameter int NUM_CH    = 4,
   parameter int ROB_DEPTH = 8
) (
   input  logic                           clk_i,
   input  logic                           rst_i,
   input  logic [NUM_CH-1:0]              ch_req_valid_i,
   output logic [NUM_CH-1:0]              ch_req_ready_o,
   input  logic [NUM_CH*OPCODE_W-1:0]     ch_req_opcode_i,
   input  logic [NUM_CH*SWO_W-1:0]        ch_req_set_way_offset_i,
   input  logic [NUM_CH*WBUF_W-1:0]       ch_req_wbuffer_id_i,
   input  logic [NUM_CH*CLSTATE_W-1:0]    ch_req_cacheline_state_i,
   output logic                           iq_valid_o,
   input  logic                           iq_allowIn_i,
   output logic [ROB_ID_W-1:0]            iq_rob_id_o,
   output logic [CH_ID_W-1:0]             iq_ch_id_o,
   output logic [OPCODE_W-1:0]            iq_opcode_o,
   output logic [SWO_W-1:0]               iq_set_way_offset_o,
   output logic [WBUF_W-1:0]              iq_wbuffer_id_o,
   output logic [CLSTATE_W-1:0]           iq_cacheline_state_o,
   input  logic                           rob_free_valid_i,
   input  logic [ROB_ID_W-1:0]            rob_free_id_i,
   output logic [ROB_DEPTH-1:0]           rob_busy_o
);

   bank_req_t            ch_req [NUM_CH];
   bank_req_t            hold_q [NUM_CH];
   logic [NUM_CH-1:0]    hold_valid_q, hold_valid_d;
   logic [NUM_CH-1:0]    accept;
   logic [CH_ID_W-1:0]   rr_ptr_q, rr_ptr_d;
   logic [ROB_DEPTH-1:0] rob_busy_q, rob_busy_d;
   logic [ROB_ID_W-1:0]  alloc_id;

   logic                 iq_valid_q;
   logic [ROB_ID_W-1:0]  iq_rob_id_q;
   logic [CH_ID_W-1:0]   iq_ch_id_q;
   bank_req_t            iq_req_q;

   logic [NUM_CH-1:0]    arb_gnt;
   logic [CH_ID_W-1:0]   arb_idx;
   logic                 arb_any;
   logic                 out_free, rob_full, grant;

   for (genvar c = 0; c < NUM_CH; c++) begin : g_unpack
      assign ch_req[c].opcode = ch_req_opcode_i[c*OPCODE_W +: OPCODE_W];
      assign ch_req[c].swo    = ch_req_set_way_offset_i[c*SWO_W +: SWO_W];
      assign ch_req[c].wbuf   = ch_req_wbuffer_id_i[c*WBUF_W +: WBUF_W];
      assign ch_req[c].state  = ch_req_cacheline_state_i[c*CLSTATE_W +: CLSTATE_W];
   end

   // Ready comes only from registered state, so a hold slot freed by a grant
   // cannot be refilled in the same cycle.
   assign ch_req_ready_o = ~hold_valid_q;
   assign accept         = ch_req_valid_i & ~hold_valid_q;

   bank_rr_arb4 u_rr_arb (
      .req_i (hold_valid_q),
      .ptr_i (rr_ptr_q),
      .gnt_o (arb_gnt),
      .idx_o (arb_idx),
      .any_o (arb_any)
   );

   assign out_free = ~iq_valid_q | iq_allowIn_i;
   assign rob_full = &rob_busy_q;
   assign grant    = out_free & arb_any & ~rob_full;
   assign alloc_id = first_clear(rob_busy_q);

   always_comb begin
      hold_valid_d = (hold_valid_q & ~(grant ? arb_gnt : '0)) | accept;
      rr_ptr_d     = grant ? arb_idx + 2'd1 : rr_ptr_q;
      // Release clears first; an allocated id is always clear so the two never collide.
      rob_busy_d   = rob_busy_q;
      if (rob_free_valid_i) rob_busy_d[rob_free_id_i] = 1'b0;
      if (grant)            rob_busy_d[alloc_id]      = 1'b1;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         hold_valid_q <= '0;
         rr_ptr_q     <= '0;
         rob_busy_q   <= '0;
         for (int c = 0; c < NUM_CH; c++) hold_q[c] <= '0;
      end else begin
         hold_valid_q <= hold_valid_d;
         rr_ptr_q     <= rr_ptr_d;
         rob_busy_q   <= rob_busy_d;
         for (int c = 0; c < NUM_CH; c++) begin
            if (accept[c]) hold_q[c] <= ch_req[c];
         end
      end
   end

   // Payload is left untouched when the stage drains so it stays stable under stall.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         iq_valid_q  <= 1'b0;
         iq_rob_id_q <= '0;
         iq_ch_id_q  <= '0;
         iq_req_q    <= '0;
      end else if (grant) begin
         iq_valid_q  <= 1'b1;
         iq_rob_id_q <= alloc_id;
         iq_ch_id_q  <= arb_idx;
         iq_req_q    <= hold_q[arb_idx];
      end else if (out_free) begin
         iq_valid_q  <= 1'b0;
      end
   end

   assign iq_valid_o           = iq_valid_q;
   assign iq_rob_id_o          = iq_rob_id_q;
   assign iq_ch_id_o           = iq_ch_id_q;
   assign iq_opcode_o          = iq_req_q.opcode;
   assign iq_set_way_offset_o  = iq_req_q.swo;
   assign iq_wbuffer_id_o      = iq_req_q.wbuf;
   assign iq_cacheline_state_o = iq_req_q.state;
   assign rob_busy_o           = rob_busy_q;

endmodule

// File: tb/tb_bank_isu_arb.sv
// Directed bench for bank_isu_arb: reset, latency, round-robin order, IQ stall,
// ROB exhaustion/release and asynchronous mid-stream reset.
module tb_bank_isu_arb;

   logic        clk_i, rst_i;
   logic [3:0]  vld, rdy;
   logic [7:0]  op;
   logic [27:0] swo;
   logic [31:0] wb;
   logic [15:0] st;
   logic        iq_valid, allow;
   logic [2:0]  iq_rob;
   logic [1:0]  iq_ch, iq_op;
   logic [6:0]  iq_swo;
   logic [7:0]  iq_wb;
   logic [3:0]  iq_st;
   logic        free_v;
   logic [2:0]  free_id;
   logic [7:0]  busy;

   int passed = 0;
   int total  = 0;

   bank_isu_arb dut (
      .clk_i                    (clk_i),
      .rst_i                    (rst_i),
      .ch_req_valid_i           (vld),
      .ch_req_ready_o           (rdy),
      .ch_req_opcode_i          (op),
      .ch_req_set_way_offset_i  (swo),
      .ch_req_wbuffer_id_i      (wb),
      .ch_req_cacheline_state_i (st),
      .iq_valid_o               (iq_valid),
      .iq_allowIn_i             (allow),
      .iq_rob_id_o              (iq_rob),
      .iq_ch_id_o               (iq_ch),
      .iq_opcode_o              (iq_op),
      .iq_set_way_offset_o      (iq_swo),
      .iq_wbuffer_id_o          (iq_wb),
      .iq_cacheline_state_o     (iq_st),
      .rob_free_valid_i         (free_v),
      .rob_free_id_i            (free_id),
      .rob_busy_o               (busy)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic set_ch(input int c, input logic [1:0] o, input logic [6:0] s,
                         input logic [7:0] w, input logic [3:0] t);
      op[2*c +: 2]  = o;
      swo[7*c +: 7] = s;
      wb[8*c +: 8]  = w;
      st[4*c +: 4]  = t;
      vld[c]        = 1'b1;
   endtask

   task automatic do_reset();
      rst_i = 1'b1; vld = '0; allow = 1'b1; free_v = 1'b0; free_id = '0;
      op = '0; swo = '0; wb = '0; st = '0;
      repeat (2) @(posedge clk_i);
      #1 rst_i = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      total++; if (rdy !== 4'hF) $display("FAIL reset_ready got=%h exp=f", rdy); else passed++;
      total++; if (iq_valid !== 1'b0) $display("FAIL reset_valid got=%b exp=0", iq_valid); else passed++;
      total++; if (busy !== 8'h00) $display("FAIL reset_busy got=%h exp=00", busy); else passed++;
      total++; if ({iq_rob, iq_ch, iq_op, iq_swo, iq_wb, iq_st} !== 26'h0)
         $display("FAIL reset_payload got=%h exp=0", {iq_rob, iq_ch, iq_op, iq_swo, iq_wb, iq_st}); else passed++;
      tick();
      total++; if (iq_valid !== 1'b0 || rdy !== 4'hF)
         $display("FAIL idle got valid=%b rdy=%h exp valid=0 rdy=f", iq_valid, rdy); else passed++;
   endtask

   task automatic test_single();
      do_reset();
      set_ch(2, 2'd1, 7'h15, 8'hA5, 4'h3);
      tick();
      vld = '0;
      total++; if (iq_valid !== 1'b0 || rdy !== 4'b1011)
         $display("FAIL single_hold got valid=%b rdy=%h exp valid=0 rdy=b", iq_valid, rdy); else passed++;
      tick();
      total++; if (iq_valid !== 1'b1) $display("FAIL single_valid got=%b exp=1", iq_valid); else passed++;
      total++; if (iq_ch !== 2'd2 || iq_rob !== 3'd0)
         $display("FAIL single_ids got ch=%0d rob=%0d exp ch=2 rob=0", iq_ch, iq_rob); else passed++;
      total++; if ({iq_op, iq_swo, iq_wb, iq_st} !== {2'd1, 7'h15, 8'hA5, 4'h3})
         $display("FAIL single_payload got=%h exp=%h", {iq_op, iq_swo, iq_wb, iq_st},
                  {2'd1, 7'h15, 8'hA5, 4'h3}); else passed++;
      total++; if (busy !== 8'h01) $display("FAIL single_busy got=%h exp=01", busy); else passed++;
      tick();
      total++; if (iq_valid !== 1'b0) $display("FAIL single_drain got=%b exp=0", iq_valid); else passed++;
      free_v = 1'b1; free_id = 3'd0;
      tick();
      free_v = 1'b0;
      total++; if (busy !== 8'h00) $display("FAIL single_release got=%h exp=00", busy); else passed++;
   endtask

   task automatic test_round_robin();
      do_reset();
      for (int c = 0; c < 4; c++) set_ch(c, 2'(c), 7'(16 + c), 8'(128 + c), 4'(8 + c));
      tick();
      vld = '0;
      total++; if (rdy !== 4'h0) $display("FAIL rr_ready got=%h exp=0", rdy); else passed++;
      for (int k = 0; k < 4; k++) begin
         tick();
         total++; if (iq_valid !== 1'b1 || iq_ch !== 2'(k) || iq_rob !== 3'(k) ||
                      iq_op !== 2'(k) || iq_wb !== 8'(128 + k) || iq_st !== 4'(8 + k))
            $display("FAIL rr_grant%0d got v=%b ch=%0d rob=%0d op=%0d wb=%h st=%h exp ch=%0d rob=%0d",
                     k, iq_valid, iq_ch, iq_rob, iq_op, iq_wb, iq_st, k, k); else passed++;
      end
      tick();
      total++; if (iq_valid !== 1'b0 || busy !== 8'h0F)
         $display("FAIL rr_end got valid=%b busy=%h exp valid=0 busy=0f", iq_valid, busy); else passed++;
      // Pointer back at 0: ch0 must beat ch3.
      set_ch(0, 2'd2, 7'h01, 8'h11, 4'h1);
      set_ch(3, 2'd3, 7'h02, 8'h22, 4'h2);
      tick();
      vld = '0;
      tick();
      total++; if (iq_ch !== 2'd0 || iq_rob !== 3'd4)
         $display("FAIL rr_ptr0 got ch=%0d rob=%0d exp ch=0 rob=4", iq_ch, iq_rob); else passed++;
      tick();
      total++; if (iq_ch !== 2'd3 || iq_rob !== 3'd5 || iq_wb !== 8'h22 || busy !== 8'h3F)
         $display("FAIL rr_next got ch=%0d rob=%0d wb=%h busy=%h exp ch=3 rob=5 wb=22 busy=3f",
                  iq_ch, iq_rob, iq_wb, busy); else passed++;
   endtask

   task automatic test_allowin_stall();
      do_reset();
      allow = 1'b0;
      for (int c = 0; c < 4; c++) set_ch(c, 2'(3 - c), 7'(64 + c), 8'(16 * c + 1), 4'(c));
      tick();
      vld = '0;
      tick();
      for (int k = 0; k < 6; k++) begin
         total++; if (iq_valid !== 1'b1 || iq_ch !== 2'd0 || iq_rob !== 3'd0 || iq_op !== 2'd3 ||
                      iq_swo !== 7'h40 || iq_wb !== 8'h01 || busy !== 8'h01 || rdy !== 4'b0001)
            $display("FAIL stall%0d got v=%b ch=%0d rob=%0d op=%0d swo=%h wb=%h busy=%h rdy=%h",
                     k, iq_valid, iq_ch, iq_rob, iq_op, iq_swo, iq_wb, busy, rdy); else passed++;
         if (k < 5) tick();
      end
      allow = 1'b1;
      tick();
      total++; if (iq_valid !== 1'b1 || iq_ch !== 2'd1 || iq_rob !== 3'd1 || iq_swo !== 7'h41 || busy !== 8'h03)
         $display("FAIL stall_resume got ch=%0d rob=%0d swo=%h busy=%h exp ch=1 rob=1 swo=41 busy=03",
                  iq_ch, iq_rob, iq_swo, busy); else passed++;
   endtask

   task automatic test_rob_full();
      do_reset();
      for (int r = 0; r < 2; r++) begin
         for (int c = 0; c < 4; c++) set_ch(c, 2'(c), 7'(c), 8'(4 * r + c), 4'(r));
         tick();
         vld = '0;
         repeat (4) tick();
      end
      total++; if (busy !== 8'hFF || iq_ch !== 2'd3 || iq_rob !== 3'd7 || iq_wb !== 8'd7)
         $display("FAIL full_fill got busy=%h ch=%0d rob=%0d wb=%h exp busy=ff ch=3 rob=7 wb=07",
                  busy, iq_ch, iq_rob, iq_wb); else passed++;
      set_ch(1, 2'd2, 7'h55, 8'hC1, 4'h9);
      tick();
      vld = '0;
      for (int k = 0; k < 3; k++) begin
         tick();
         total++; if (iq_valid !== 1'b0 || rdy !== 4'b1101 || busy !== 8'hFF)
            $display("FAIL full_stall%0d got valid=%b rdy=%h busy=%h exp valid=0 rdy=d busy=ff",
                     k, iq_valid, rdy, busy); else passed++;
      end
      free_v = 1'b1; free_id = 3'd5;
      tick();
      free_v = 1'b0;
      total++; if (iq_valid !== 1'b0 || busy !== 8'hDF)
         $display("FAIL full_release got valid=%b busy=%h exp valid=0 busy=df", iq_valid, busy); else passed++;
      tick();
      total++; if (iq_valid !== 1'b1 || iq_ch !== 2'd1 || iq_rob !== 3'd5 || iq_wb !== 8'hC1 || busy !== 8'hFF)
         $display("FAIL full_regrant got v=%b ch=%0d rob=%0d wb=%h busy=%h exp v=1 ch=1 rob=5 wb=c1 busy=ff",
                  iq_valid, iq_ch, iq_rob, iq_wb, busy); else passed++;
      free_v = 1'b1; free_id = 3'd5;
      tick();
      total++; if (busy !== 8'hDF || iq_valid !== 1'b0)
         $display("FAIL free5 got busy=%h valid=%b exp busy=df valid=0", busy, iq_valid); else passed++;
      tick();
      free_v = 1'b0;
      total++; if (busy !== 8'hDF || iq_valid !== 1'b0)
         $display("FAIL free5_again got busy=%h valid=%b exp busy=df valid=0", busy, iq_valid); else passed++;
   endtask

   task automatic test_mid_reset();
      do_reset();
      allow = 1'b0;
      for (int c = 0; c < 4; c++) set_ch(c, 2'd3, 7'h7F, 8'hFF, 4'hF);
      tick();
      vld = '0;
      tick();
      total++; if (rdy !== 4'b0001 || iq_valid !== 1'b1 || busy !== 8'h01)
         $display("FAIL pre_reset got rdy=%h valid=%b busy=%h exp rdy=1 valid=1 busy=01",
                  rdy, iq_valid, busy); else passed++;
      #2 rst_i = 1'b1;
      #1;
      total++; if (rdy !== 4'hF || iq_valid !== 1'b0 || busy !== 8'h00)
         $display("FAIL async_reset got rdy=%h valid=%b busy=%h exp rdy=f valid=0 busy=00",
                  rdy, iq_valid, busy); else passed++;
      total++; if ({iq_op, iq_swo, iq_wb, iq_st} !== 21'h0)
         $display("FAIL async_reset_payload got=%h exp=0", {iq_op, iq_swo, iq_wb, iq_st}); else passed++;
      @(posedge clk_i);
      #1 rst_i = 1'b0;
      allow = 1'b1;
      repeat (3) tick();
      total++; if (iq_valid !== 1'b0 || busy !== 8'h00 || rdy !== 4'hF)
         $display("FAIL post_reset got valid=%b busy=%h rdy=%h exp valid=0 busy=00 rdy=f",
                  iq_valid, busy, rdy); else passed++;
   endtask

   initial begin
      test_reset();
      test_single();
      test_round_robin();
      test_allowin_stall();
      test_rob_full();
      test_mid_reset();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
